// File: rtl/fetch_hazard_ctrl.sv
// Fetch/hazard sequencing for the 5-stage core: PC control, IF/ID hold
// and stage flushes for load-use, branch redirects and imem waits.
module fetch_hazard_ctrl #(
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_ready,
    input  logic              ex_mem_pc_src,
    input  logic [ADDR_W-1:0] ex_mem_npc,
    input  logic              id_ex_mem_read,
    input  logic [REG_W-1:0]  id_ex_rt,
    input  logic [REG_W-1:0]  if_id_rs,
    input  logic [REG_W-1:0]  if_id_rt,
    input  logic              if_id_uses_rt,
    output logic              imem_req,
    output logic              pc_write,
    output logic              pc_sel,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        IMEM_WAIT  = 2'd1,
        WAIT_REDIR = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] pend_pc;
    logic [ADDR_W-1:0] pend_nxt;
    logic              stall_inc;
    logic              flush_inc;
    logic              lu;

    assign lu = id_ex_mem_read && (id_ex_rt != '0) &&
                ((id_ex_rt == if_id_rs) ||
                 (if_id_uses_rt && (id_ex_rt == if_id_rt)));

    always_comb begin
        imem_req     = 1'b1;
        pc_write     = 1'b1;
        pc_sel       = 1'b0;
        redirect_pc  = ex_mem_npc;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        stall_inc    = 1'b0;
        flush_inc    = 1'b0;
        state_nxt    = state;
        pend_nxt     = pend_pc;
        if (rst) begin
            imem_req     = 1'b0;
            pc_write     = 1'b0;
            redirect_pc  = '0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_nxt    = RUN;
            pend_nxt     = '0;
        end else begin
            unique case (state)
                RUN, IMEM_WAIT: begin
                    if (ex_mem_pc_src) begin
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                        flush_inc    = 1'b1;
                        if (imem_ready) begin
                            pc_sel    = 1'b1;
                            state_nxt = RUN;
                        end else begin
                            pc_write  = 1'b0;
                            pend_nxt  = ex_mem_npc;
                            state_nxt = WAIT_REDIR;
                        end
                    end else if (!imem_ready || lu) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        stall_inc   = 1'b1;
                        state_nxt   = imem_ready ? RUN : IMEM_WAIT;
                    end else begin
                        state_nxt = RUN;
                    end
                end
                WAIT_REDIR: begin
                    // Word in flight belongs to the squashed path; drop it.
                    pc_write    = 1'b0;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    if (ex_mem_pc_src) begin
                        ex_mem_flush = 1'b1;
                        flush_inc    = 1'b1;
                        pend_nxt     = ex_mem_npc;
                    end
                    if (imem_ready) begin
                        pc_write    = 1'b1;
                        pc_sel      = 1'b1;
                        redirect_pc = ex_mem_pc_src ? ex_mem_npc : pend_pc;
                        state_nxt   = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            pend_pc   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state   <= state_nxt;
            pend_pc <= pend_nxt;
            if (stall_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
